// File: rtl/psram_pkg.sv
// Shared PSRAM controller types: FSM state encoding, CA field layout and CA builder.
// Latency: none. This file holds declarations only.
// Backpressure: none.
package psram_pkg;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_CFG_CA,
        ST_CFG_DATA,
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_WRITE,
        ST_READ,
        ST_CS_HIGH
    } psram_state_e;

    // The 48-bit command/address word goes out 16 bits per beat, MSB first.
    localparam int CA_W         = 48;
    localparam int CA_BEATS     = 3;
    localparam int CA_RW_BIT    = 47;   // 1 = read
    localparam int CA_AS_BIT    = 46;   // 1 = register space
    localparam int CA_BURST_BIT = 45;   // 1 = linear burst
    localparam int CA_ROW_LSB   = 16;
    localparam int CA_ROW_W     = 19;   // addr[21:3]; bits [44:35] stay zero
    localparam int CA_COL_W     = 3;    // addr[2:0] in CA[2:0]

    // Word address that lands CR0 at CA 48'h6000_0100_0000 once build_ca is applied.
    localparam logic [21:0] CR0_ADDR = 22'h000800;

    function automatic logic [CA_W-1:0] build_ca(input logic        rw,
                                                 input logic        as_reg,
                                                 input logic [21:0] addr);
        logic [CA_W-1:0] ca;
        ca                             = '0;
        ca[CA_RW_BIT]                  = rw;
        ca[CA_AS_BIT]                  = as_reg;
        ca[CA_BURST_BIT]               = 1'b1;
        ca[CA_ROW_LSB +: CA_ROW_W]     = addr[21:CA_COL_W];
        ca[CA_COL_W-1:0]               = addr[CA_COL_W-1:0];
        return ca;
    endfunction

endpackage

// File: rtl/psram_ca_shift.sv
// Loads a 48-bit CA word and presents it 16 bits per cycle, MSB pair first.
// Latency: the first word is visible the cycle after load_i; done_o marks the third word.
// Backpressure: none. The word advances on every cycle that adv_i is high.
module psram_ca_shift
    import psram_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [CA_W-1:0] ca_i,
    input  logic            adv_i,
    output logic [15:0]     word_o,
    output logic            done_o
);

    logic [CA_W-1:0] sh_q, sh_d;
    logic [1:0]      idx_q, idx_d;

    // A load wins over an advance, so a new access always starts on beat 0.
    always_comb begin
        sh_d  = sh_q;
        idx_d = idx_q;
        if (load_i) begin
            sh_d  = ca_i;
            idx_d = '0;
        end else if (adv_i) begin
            sh_d  = {sh_q[CA_W-17:0], 16'h0000};
            idx_d = idx_q + 2'd1;
        end
    end

    // Hold the shift register and beat index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else begin
            sh_q  <= sh_d;
            idx_q <= idx_d;
        end
    end

    assign word_o = sh_q[CA_W-1 -: 16];
    assign done_o = (idx_q == 2'(CA_BEATS - 1));

endmodule

// File: rtl/psram_cmd_ctrl.sv
// HyperBus-style PSRAM controller: power-up wait, CR0 programming, then one burst per command.
// Latency: the CA starts the cycle after cmd accept; a read word is forwarded one cycle after phy_rd_valid.
// Backpressure: cmd_ready is high only in IDLE after init. Write data must follow wr_ack every cycle.
module psram_cmd_ctrl
    import psram_pkg::*;
#(
    parameter int          CLK_MHZ     = 54,
    parameter int          INIT_US     = 150,
    parameter int          LATENCY     = 3,
    parameter int          BURST_WORDS = 4,
    parameter int          CSHI_CYCLES = 2,
    parameter logic [15:0] CR0_VALUE   = 16'h8F2C,
    parameter int          RD_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [21:0] cmd_addr,
    input  logic [15:0] wr_data,
    input  logic [1:0]  wr_mask,
    output logic        wr_ack,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        rd_error,
    output logic        init_done,
    output logic        psram_ck_en,
    output logic        psram_cs_n,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic [1:0]  rwds_out,
    output logic        rwds_oe,
    input  logic [15:0] phy_rd_word,
    input  logic        phy_rd_valid
);

    // resetn is expected to be released synchronously to clk by the reset generator.
    localparam int INIT_CYCLES = CLK_MHZ * INIT_US;
    localparam int CNT_MAX     = (INIT_CYCLES > RD_TIMEOUT) ? INIT_CYCLES : RD_TIMEOUT;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam int WC_W        = $clog2(BURST_WORDS + 1);

    psram_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WC_W-1:0]  rd_words_q, rd_words_d;
    logic             write_q, write_d;
    logic             init_done_q, init_done_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_error_q, rd_error_d;

    logic             ca_load;
    logic [CA_W-1:0]  ca_val;
    logic             ca_adv;
    logic [15:0]      ca_word;
    logic             ca_done;
    logic             rd_last;
    logic             rd_timeout;

    psram_ca_shift u_ca_shift (
        .clk    (clk),
        .rst_n  (resetn),
        .load_i (ca_load),
        .ca_i   (ca_val),
        .adv_i  (ca_adv),
        .word_o (ca_word),
        .done_o (ca_done)
    );

    // A word that completes the burst on the final timeout cycle counts as success.
    // Otherwise a word arriving on that cycle is dropped, so rd_valid and rd_error never overlap.
    assign rd_last    = phy_rd_valid && (rd_words_q == WC_W'(BURST_WORDS - 1));
    assign rd_timeout = (cnt_q == CNT_W'(RD_TIMEOUT - 1)) && !rd_last;

    // Next-state, counters and bus outputs. Bus pins follow the state directly so reset idles them at once.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        rd_words_d  = rd_words_q;
        write_d     = write_q;
        init_done_d = init_done_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        rd_error_d  = 1'b0;
        ca_load     = 1'b0;
        ca_val      = build_ca(~cmd_write, 1'b0, cmd_addr);
        ca_adv      = 1'b0;
        cmd_ready   = 1'b0;
        wr_ack      = 1'b0;
        psram_ck_en = 1'b0;
        psram_cs_n  = 1'b1;
        dq_out      = '0;
        dq_oe       = 1'b0;
        rwds_out    = '0;
        rwds_oe     = 1'b0;

        unique case (state_q)
            ST_INIT_WAIT: begin
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    state_d = ST_CFG_CA;
                    cnt_d   = '0;
                    ca_load = 1'b1;
                    ca_val  = build_ca(1'b0, 1'b1, CR0_ADDR);
                end
            end
            ST_CFG_CA, ST_CA: begin
                psram_cs_n  = 1'b0;
                psram_ck_en = 1'b1;
                dq_oe       = 1'b1;
                dq_out      = ca_word;
                ca_adv      = 1'b1;
                cnt_d       = '0;
                if (ca_done) begin
                    state_d = (state_q == ST_CFG_CA) ? ST_CFG_DATA : ST_LAT;
                end
            end
            ST_CFG_DATA: begin
                // Register writes carry no latency and no RWDS masking.
                psram_cs_n  = 1'b0;
                psram_ck_en = 1'b1;
                dq_oe       = 1'b1;
                dq_out      = CR0_VALUE;
                state_d     = ST_CS_HIGH;
                cnt_d       = '0;
            end
            ST_IDLE: begin
                cnt_d     = '0;
                cmd_ready = init_done_q;
                if (cmd_valid && init_done_q) begin
                    write_d = cmd_write;
                    ca_load = 1'b1;
                    state_d = ST_CA;
                end
            end
            ST_LAT: begin
                psram_cs_n  = 1'b0;
                psram_ck_en = 1'b1;
                if (cnt_q == CNT_W'(2 * LATENCY - 1)) begin
                    state_d    = write_q ? ST_WRITE : ST_READ;
                    cnt_d      = '0;
                    rd_words_d = '0;
                end
            end
            ST_WRITE: begin
                psram_cs_n  = 1'b0;
                psram_ck_en = 1'b1;
                wr_ack      = 1'b1;
                dq_oe       = 1'b1;
                dq_out      = wr_data;
                rwds_oe     = 1'b1;
                rwds_out    = ~wr_mask;
                if (cnt_q == CNT_W'(BURST_WORDS - 1)) begin
                    state_d = ST_CS_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                psram_cs_n  = 1'b0;
                psram_ck_en = 1'b1;
                if (phy_rd_valid && !rd_timeout) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = phy_rd_word;
                    rd_words_d = rd_words_q + WC_W'(1);
                end
                if (rd_last) begin
                    state_d = ST_CS_HIGH;
                    cnt_d   = '0;
                end else if (rd_timeout) begin
                    rd_error_d = 1'b1;
                    state_d    = ST_CS_HIGH;
                    cnt_d      = '0;
                end
            end
            ST_CS_HIGH: begin
                // init_done rises on the way out so the first cmd_ready coincides with it.
                if (cnt_q == CNT_W'(CSHI_CYCLES - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = ST_INIT_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers. Any reset reruns the full power-up sequence.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_INIT_WAIT;
            cnt_q       <= '0;
            rd_words_q  <= '0;
            write_q     <= 1'b0;
            init_done_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_words_q  <= rd_words_d;
            write_q     <= write_d;
            init_done_q <= init_done_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_error_q  <= rd_error_d;
        end
    end

    assign init_done = init_done_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_error  = rd_error_q;

endmodule

// File: tb/tb_psram_cmd_ctrl.sv
// Self-checking bench for psram_cmd_ctrl: directed init/write/read/timeout/reset cases plus random accesses.
// A cycle-level reference model built from the bus protocol rules produces every expected value.
// The bench plays the role of both the user port and the pad-side phy.
module tb_psram_cmd_ctrl;

    localparam int BURST    = 4;
    localparam int LAT2     = 6;
    localparam int TIMEOUT  = 64;
    localparam int INIT_CYC = 8100;

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [21:0] cmd_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_mask;
    logic        wr_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_error;
    logic        init_done;
    logic        psram_ck_en;
    logic        psram_cs_n;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [1:0]  rwds_out;
    logic        rwds_oe;
    logic [15:0] phy_rd_word;
    logic        phy_rd_valid;

    int checks = 0;
    int errors = 0;

    logic [15:0] wdat [4];
    logic [15:0] rdat [4];
    logic [1:0]  wmask;
    logic [15:0] cfg_words [3] = '{16'h6000, 16'h0100, 16'h0000};

    psram_cmd_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .wr_data      (wr_data),
        .wr_mask      (wr_mask),
        .wr_ack       (wr_ack),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_error     (rd_error),
        .init_done    (init_done),
        .psram_ck_en  (psram_ck_en),
        .psram_cs_n   (psram_cs_n),
        .dq_out       (dq_out),
        .dq_oe        (dq_oe),
        .rwds_out     (rwds_out),
        .rwds_oe      (rwds_oe),
        .phy_rd_word  (phy_rd_word),
        .phy_rd_valid (phy_rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CA word from the field rules: R/W#, address space, linear burst, row = addr/8, column = addr%8.
    function automatic logic [47:0] model_ca(input bit rd, input bit reg_space, input logic [21:0] addr);
        logic [47:0] v;
        v = (48'(rd) << 47) | (48'(reg_space) << 46) | (48'd1 << 45)
          | (48'(addr >> 3) << 16) | 48'(addr % 22'd8);
        return v;
    endfunction

    // Expects to start on the first cycle after reset release; cmd_valid is held high during the wait.
    task automatic do_init();
        int n;
        int bad;
        chk("reset_outs", {psram_cs_n, cmd_ready, wr_ack, rd_valid, rd_error, init_done, psram_ck_en,
                           dq_oe, rwds_oe, rwds_out, dq_out, rd_data}, {1'b1, 42'h0});
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 22'h3FFFFF;
        n   = 0;
        bad = 0;
        while (psram_cs_n && n < INIT_CYC + 500) begin
            if (cmd_ready || dq_oe || psram_ck_en || init_done) bad++;
            step();
            n++;
        end
        cmd_valid = 1'b0;
        chk("init_wait_cycles", 64'(n), 64'(INIT_CYC));
        chk("init_quiet", 64'(bad), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("cfg_ca", {psram_cs_n, psram_ck_en, dq_oe, cmd_ready, dq_out}, {4'b0110, cfg_words[i]});
            step();
        end
        chk("cfg_data", {psram_cs_n, psram_ck_en, dq_oe, rwds_oe, dq_out}, {4'b0110, 16'h8F2C});
        step();
        chk("cfg_cs_rise", {psram_cs_n, psram_ck_en, init_done, cmd_ready}, 4'b1000);
        step();
        chk("cfg_cs_hold", {psram_cs_n, init_done, cmd_ready}, 3'b100);
        step();
        chk("init_done_rise", {psram_cs_n, init_done, cmd_ready}, 3'b111);
    endtask

    // One user access. nret = words the phy returns on a read; abort_beat = write beat at which reset hits.
    task automatic access(input bit wr, input logic [21:0] addr, input int nret, input int abort_beat);
        logic [47:0] ca;
        logic [15:0] exp_d;
        logic [15:0] w;
        int          n;
        int          sent;
        int          c;
        bit          fin;
        bit          exp_v;
        bit          exp_err;
        bit          v;

        ca = model_ca(!wr, 1'b0, addr);
        n  = 0;
        while (!cmd_ready && n < 100) begin
            step();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        wr_data   = wdat[0];
        wr_mask   = wmask;
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 22'($urandom);

        for (int i = 0; i < 3; i++) begin
            chk("ca_word", {psram_cs_n, psram_ck_en, dq_oe, cmd_ready, dq_out},
                {4'b0110, 16'(ca >> (32 - 16 * i))});
            step();
        end
        for (int i = 0; i < LAT2; i++) begin
            chk("latency", {psram_cs_n, psram_ck_en, dq_oe, rwds_oe, wr_ack, rd_valid}, 6'b010000);
            if (!wr) begin
                phy_rd_valid = 1'b1;
                phy_rd_word  = 16'($urandom);
            end
            step();
        end

        exp_v   = 1'b0;
        exp_err = 1'b0;
        exp_d   = '0;
        if (wr) begin
            for (int i = 0; i < BURST; i++) begin
                if (i == abort_beat) begin
                    resetn = 1'b0;
                    #1;
                    chk("abort_bus", {psram_cs_n, dq_oe, rwds_oe, psram_ck_en, wr_ack, init_done}, 6'b100000);
                    return;
                end
                chk("wr_beat", {psram_cs_n, wr_ack, dq_oe, rwds_oe, rwds_out, dq_out},
                    {4'b0111, ~wmask, wdat[i]});
                step();
                if (i < BURST - 1) wr_data = wdat[i + 1];
                #1;
            end
        end else begin
            sent = 0;
            c    = 0;
            fin  = 1'b0;
            while (!fin) begin
                chk("rd_phase", {psram_cs_n, psram_ck_en, dq_oe, rwds_oe, rd_error}, 5'b01000);
                chk("rd_valid", rd_valid, exp_v);
                if (exp_v) chk("rd_data", rd_data, exp_d);
                v = (sent < nret) && ($urandom_range(0, 2) != 0);
                w = 16'($urandom);
                if (v) w = rdat[sent];
                phy_rd_valid = v;
                phy_rd_word  = w;
                if (v && sent == BURST - 1) begin
                    exp_v = 1'b1;
                    exp_d = w;
                    fin   = 1'b1;
                end else if (c == TIMEOUT - 1) begin
                    exp_v   = 1'b0;
                    exp_err = 1'b1;
                    fin     = 1'b1;
                end else begin
                    exp_v = v;
                    if (v) exp_d = w;
                end
                if (v) sent++;
                step();
                c++;
            end
        end

        chk("cs_rise", {psram_cs_n, psram_ck_en, dq_oe, wr_ack, cmd_ready}, 5'b10000);
        chk("end_rd_valid", rd_valid, exp_v);
        if (exp_v) chk("end_rd_data", rd_data, exp_d);
        chk("rd_error", rd_error, exp_err);
        phy_rd_valid = 1'b1;
        phy_rd_word  = 16'hDEAD;
        step();
        phy_rd_valid = 1'b0;
        chk("cs_hold", {psram_cs_n, cmd_ready, rd_valid, rd_error}, 4'b1000);
        step();
        chk("back_idle", {psram_cs_n, cmd_ready}, 2'b11);
    endtask

    initial begin
        resetn       = 1'b0;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = '0;
        wr_data      = '0;
        wr_mask      = '0;
        phy_rd_valid = 1'b0;
        phy_rd_word  = '0;
        wmask        = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wdat[j] = '0;
            rdat[j] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        do_init();

        wdat  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        wmask = 2'b11;
        access(1'b1, 22'h12345, 0, -1);

        rdat = '{16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0};
        access(1'b0, 22'h00007, 4, -1);

        rdat = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        access(1'b0, 22'h2A000, 2, -1);

        wmask = 2'b01;
        access(1'b1, 22'h3FFFF8, 0, -1);

        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 4; j++) begin
                wdat[j] = 16'($urandom);
                rdat[j] = 16'($urandom);
            end
            wmask = 2'($urandom);
            access(1'($urandom), 22'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : BURST, -1);
        end

        for (int j = 0; j < 4; j++) wdat[j] = 16'($urandom);
        wmask = 2'b10;
        access(1'b1, 22'($urandom), 0, 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        do_init();

        for (int j = 0; j < 4; j++) begin
            wdat[j] = 16'($urandom);
            rdat[j] = 16'($urandom);
        end
        access(1'b1, 22'h001000, 0, -1);
        access(1'b0, 22'h001000, 4, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
